// File: rtl/perf_counter_bank_if.sv
// Handshake bundle for the performance counter bank.
// The bench or host core drives the master side; the counter bank is the slave.
interface perf_counter_bank_if #(
    parameter int WIDTH  = 16,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = 2
);
    logic [NUM_CH-1:0] events;
    logic              start;
    logic              stop;
    logic              clear;
    logic              snap;
    logic [SEL_W-1:0]  sel;
    logic              rd_live;
    logic [WIDTH-1:0]  count_out;
    logic [NUM_CH-1:0] ovf;
    logic              snap_valid;
    logic              running;

    modport master (
        output events, start, stop, clear, snap, sel, rd_live,
        input  count_out, ovf, snap_valid, running
    );

    modport slave (
        input  events, start, stop, clear, snap, sel, rd_live,
        output count_out, ovf, snap_valid, running
    );
endinterface

// File: rtl/perf_counter_bank.sv
// Multi-channel event counter bank with start/halt control,
// sticky overflow flags and a snapshot register bank.
module perf_counter_bank #(
    parameter int WIDTH  = 16,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = 2,
    parameter int SAT    = 0
) (
    input logic           clock,
    input logic           reset,
    perf_counter_bank_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] MAX = '1;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t state;
    state_t state_nx;

    logic [WIDTH-1:0]  live   [NUM_CH];
    logic [WIDTH-1:0]  shadow [NUM_CH];
    logic [NUM_CH-1:0] ovf_q;
    logic              valid_q;
    logic              count_en;
    logic              take_snap;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // clear overrides both the transition and any capture or count
    always_comb begin
        state_nx  = state;
        count_en  = 1'b0;
        take_snap = bus.snap;
        unique case (state)
            IDLE: begin
                if (bus.start && !bus.stop) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (bus.stop) begin
                    state_nx  = HALTED;
                    take_snap = 1'b1;
                end else begin
                    count_en = 1'b1;
                end
            end
            HALTED: begin
                if (bus.start && !bus.stop) begin
                    state_nx = RUN;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        if (bus.clear) begin
            state_nx  = IDLE;
            count_en  = 1'b0;
            take_snap = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                live[i]   <= '0;
                shadow[i] <= '0;
            end
            ovf_q   <= '0;
            valid_q <= 1'b0;
        end else if (bus.clear) begin
            for (int i = 0; i < NUM_CH; i++) begin
                live[i]   <= '0;
                shadow[i] <= '0;
            end
            ovf_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (take_snap) begin
                    shadow[i] <= live[i];
                end
                if (count_en && bus.events[i]) begin
                    if (live[i] == MAX) begin
                        ovf_q[i] <= 1'b1;
                        live[i]  <= (SAT != 0) ? MAX : '0;
                    end else begin
                        live[i] <= live[i] + ONE;
                    end
                end
            end
            if (take_snap) begin
                valid_q <= 1'b1;
            end
        end
    end

    // unpopulated select codes read as zero
    always_comb begin
        bus.count_out = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (int'(bus.sel) == i) begin
                bus.count_out = bus.rd_live ? live[i] : shadow[i];
            end
        end
    end

    assign bus.ovf        = ovf_q;
    assign bus.snap_valid = valid_q;
    assign bus.running    = (state == RUN);
endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench for perf_counter_bank: default build plus
// 4-bit wrap and saturate builds with three channels.
module tb_perf_counter_bank;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    perf_counter_bank_if #(.WIDTH(16), .NUM_CH(4), .SEL_W(2)) ia ();
    perf_counter_bank_if #(.WIDTH(4), .NUM_CH(3), .SEL_W(2)) iw ();
    perf_counter_bank_if #(.WIDTH(4), .NUM_CH(3), .SEL_W(2)) isat ();

    perf_counter_bank #(.WIDTH(16), .NUM_CH(4), .SEL_W(2), .SAT(0)) dut_a (
        .clock(clock), .reset(reset), .bus(ia.slave)
    );
    perf_counter_bank #(.WIDTH(4), .NUM_CH(3), .SEL_W(2), .SAT(0)) dut_w (
        .clock(clock), .reset(reset), .bus(iw.slave)
    );
    perf_counter_bank #(.WIDTH(4), .NUM_CH(3), .SEL_W(2), .SAT(1)) dut_s (
        .clock(clock), .reset(reset), .bus(isat.slave)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        ia.events = '0; ia.start = 0; ia.stop = 0; ia.clear = 0;
        ia.snap = 0; ia.sel = '0; ia.rd_live = 1;
        iw.events = '0; iw.start = 0; iw.stop = 0; iw.clear = 0;
        iw.snap = 0; iw.sel = '0; iw.rd_live = 1;
        isat.events = '0; isat.start = 0; isat.stop = 0; isat.clear = 0;
        isat.snap = 0; isat.sel = '0; isat.rd_live = 1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (2) tick();
        ia.rd_live = 1; #1;
        checks++;
        if (ia.count_out !== 16'd0) begin
            errors++;
            $display("FAIL reset_live got %0d want 0", ia.count_out);
        end
        ia.rd_live = 0; #1;
        checks++;
        if (ia.count_out !== 16'd0) begin
            errors++;
            $display("FAIL reset_snap got %0d want 0", ia.count_out);
        end
        checks++;
        if ({ia.ovf, ia.snap_valid, ia.running} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 000000",
                     {ia.ovf, ia.snap_valid, ia.running});
        end
        ia.rd_live = 1;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_run_halt();
        ia.start = 1; tick();
        ia.start = 0;
        checks++;
        if (ia.running !== 1'b1) begin
            errors++;
            $display("FAIL run_rise got %b want 1", ia.running);
        end
        ia.events = 4'b0001;
        repeat (10) tick();
        ia.events = '0;
        ia.stop = 1; tick();
        ia.sel = 0; ia.rd_live = 1; #1;
        checks++;
        if (ia.count_out !== 16'd10) begin
            errors++;
            $display("FAIL halt_live got %0d want 10", ia.count_out);
        end
        ia.rd_live = 0; #1;
        checks++;
        if (ia.count_out !== 16'd10) begin
            errors++;
            $display("FAIL halt_snap got %0d want 10", ia.count_out);
        end
        checks++;
        if ({ia.snap_valid, ia.running} !== 2'b10) begin
            errors++;
            $display("FAIL halt_flags got %b want 10",
                     {ia.snap_valid, ia.running});
        end
        ia.rd_live = 1;
    endtask

    task automatic test_resume();
        // halted at 10: resume and count up to 20
        ia.stop = 0; ia.start = 1; tick();
        ia.start = 0; ia.events = 4'b0001;
        repeat (10) tick();
        ia.events = 4'b0001; ia.stop = 1; tick();
        ia.events = '0;
        // start with stop still high must be ignored
        ia.start = 1; tick();
        ia.start = 0; ia.sel = 0; ia.rd_live = 1; #1;
        checks++;
        if ({ia.running, ia.count_out} !== {1'b0, 16'd20}) begin
            errors++;
            $display("FAIL start_blocked got run=%b cnt=%0d want run=0 cnt=20",
                     ia.running, ia.count_out);
        end
        ia.stop = 0; ia.start = 1; tick();
        ia.start = 0; ia.events = 4'b0001;
        repeat (3) tick();
        ia.events = '0; #1;
        checks++;
        if ({ia.running, ia.count_out} !== {1'b1, 16'd23}) begin
            errors++;
            $display("FAIL resume got run=%b cnt=%0d want run=1 cnt=23",
                     ia.running, ia.count_out);
        end
    endtask

    task automatic test_snap_clear();
        ia.clear = 1; tick();
        ia.clear = 0;
        ia.start = 1; tick();
        ia.start = 0; ia.events = 4'b0100;
        repeat (5) tick();
        ia.snap = 1; tick();
        ia.snap = 0; ia.events = '0;
        ia.sel = 2; ia.rd_live = 0; #1;
        checks++;
        if (ia.count_out !== 16'd5) begin
            errors++;
            $display("FAIL snap_old got %0d want 5", ia.count_out);
        end
        ia.rd_live = 1; #1;
        checks++;
        if (ia.count_out !== 16'd6) begin
            errors++;
            $display("FAIL snap_live got %0d want 6", ia.count_out);
        end
        ia.clear = 1; ia.events = 4'b1111; ia.snap = 1; tick();
        ia.clear = 0; ia.events = '0; ia.snap = 0; #1;
        checks++;
        if ({ia.count_out, ia.ovf, ia.snap_valid, ia.running}
            !== {16'd0, 4'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL clear got cnt=%0d ovf=%b sv=%b run=%b want 0",
                     ia.count_out, ia.ovf, ia.snap_valid, ia.running);
        end
        ia.rd_live = 0; #1;
        checks++;
        if (ia.count_out !== 16'd0) begin
            errors++;
            $display("FAIL clear_snap got %0d want 0", ia.count_out);
        end
        ia.rd_live = 1;
    endtask

    task automatic test_wrap_sat();
        iw.start = 1; isat.start = 1; tick();
        iw.start = 0; isat.start = 0;
        iw.events = 3'b010; isat.events = 3'b010;
        repeat (15) tick();
        checks++;
        if ({iw.ovf, isat.ovf} !== 6'b000000) begin
            errors++;
            $display("FAIL ovf_early got w=%b s=%b want 000 000",
                     iw.ovf, isat.ovf);
        end
        repeat (2) tick();
        iw.events = '0; isat.events = '0;
        iw.sel = 1; isat.sel = 1; #1;
        checks++;
        if ({iw.count_out, iw.ovf} !== {4'd1, 3'b010}) begin
            errors++;
            $display("FAIL wrap got cnt=%0d ovf=%b want cnt=1 ovf=010",
                     iw.count_out, iw.ovf);
        end
        checks++;
        if ({isat.count_out, isat.ovf} !== {4'd15, 3'b010}) begin
            errors++;
            $display("FAIL sat got cnt=%0d ovf=%b want cnt=15 ovf=010",
                     isat.count_out, isat.ovf);
        end
        iw.sel = 3; #1;
        checks++;
        if (iw.count_out !== 4'd0) begin
            errors++;
            $display("FAIL sel_oob got %0d want 0", iw.count_out);
        end
        // ovf stays set after a halt/resume cycle
        iw.stop = 1; tick();
        iw.stop = 0; iw.start = 1; tick();
        iw.start = 0; #1;
        checks++;
        if (iw.ovf !== 3'b010) begin
            errors++;
            $display("FAIL ovf_sticky got %b want 010", iw.ovf);
        end
    endtask

    task automatic test_async_reset();
        ia.start = 1; tick();
        ia.start = 0; ia.events = 4'b1001; ia.snap = 1; tick();
        ia.snap = 0;
        repeat (3) tick();
        ia.sel = 3; ia.rd_live = 1; #1;
        checks++;
        if (ia.count_out !== 16'd4) begin
            errors++;
            $display("FAIL pre_reset got %0d want 4", ia.count_out);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({ia.count_out, ia.ovf, ia.snap_valid, ia.running}
            !== {16'd0, 4'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset got cnt=%0d sv=%b run=%b want 0",
                     ia.count_out, ia.snap_valid, ia.running);
        end
        idle_inputs();
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_run_halt();
        test_resume();
        test_snap_clear();
        test_wrap_sat();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/perf_counter_bank.md
# perf_counter_bank

Parametrised multi-channel performance-monitor block for the pipelined processor, generalising the single 16-bit halt-gated cycle counter into NUM_CH independent event counters. Each counter has configurable width and wrap/saturate mode, plus sticky overflow flags, a start/halt state machine, and a snapshot register bank. It sits beside the datapath: channel 0 is tied to constant 1 (cycles), other channels to pipeline strobes (IR4 load, stalls, taken branches). `count_out` feeds the HEX display muxes.

## Interface
- WIDTH, 16, counter and snapshot width in bits (2..32)
- NUM_CH, 4, number of event channels (1..2^SEL_W)
- SEL_W, 2, width of channel-select input
- SAT, 0, 0 = counters wrap at 2^WIDTH-1, 1 = counters saturate there
- clock  in  1  rising-edge clock; one clock domain
- reset  in  1  asynchronous, active-high; clears all state immediately
- event  in  NUM_CH  per-channel increment strobe, sampled each rising edge
- start  in  1  pulse: begin/resume counting
- stop  in  1  level: processor halted (the wb-stage Stop)
- clear  in  1  synchronous clear of counters, snapshots, flags; returns to IDLE
- snap  in  1  pulse: copy all live counters into snapshot bank
- sel  in  SEL_W  channel to present on count_out
- rd_live  in  1  1 = count_out shows live counter, 0 = snapshot
- count_out  out  WIDTH  selected value (combinational from registers)
- ovf  out  NUM_CH  sticky per-channel overflow flags
- snap_valid  out  1  snapshot bank holds a capture since last clear/reset
- running  out  1  high only in state RUN

## Operation
- States: IDLE (reset state), RUN, HALTED.
  - IDLE -> RUN: start=1 and stop=0.
  - RUN -> HALTED: stop=1. This is an automatic snapshot; snap_valid <= 1.
  - HALTED -> RUN: start=1 and stop=0. Counters are not cleared.
  - Any state -> IDLE: clear=1.
  - start is ignored while stop=1.
- Counting happens only in RUN with stop=0. Channel i increments by 1 on an edge where event[i]=1.
- Counting is frozen in IDLE and HALTED. An event in the same cycle stop rises is not counted.
- Wrap (SAT=0): value 2^WIDTH-1 plus event -> 0, and ovf[i] <= 1.
- Saturate (SAT=1): value held at 2^WIDTH-1; ovf[i] <= 1 on the first event that arrives at max.
- ovf bits are sticky; only clear or reset lowers them.
- Explicit snap is accepted in any state. It copies every live counter (pre-edge value) into snapshots and sets snap_valid.
- Priority per edge: clear > snapshot (explicit or automatic) > increment.
  - clear with event or snap: all counters, snapshots, ovf and snap_valid go to 0; state IDLE.
  - snap with event: snapshot gets the old value, live counter gets old+1.
- count_out = live[sel] if rd_live else snap[sel]. If sel >= NUM_CH, count_out = 0.

## Timing
- Reset values: all counters, all snapshots, count_out, ovf, snap_valid and running are 0; state IDLE. Reset asserted mid-count clears asynchronously with no edge needed.
- An event sampled at edge k is visible on count_out (rd_live=1) right after edge k: 1-cycle latency from event to register.
- running rises the cycle after the start edge and falls the cycle after the stop edge.
- Snapshot data is visible on count_out (rd_live=0) right after the capture edge.
- sel and rd_live affect count_out combinationally, with no added latency.

## Test plan
- Reset, start=1 for one cycle, event[0]=1 held for 10 cycles, stop=1 -> live[0]=10, snap[0]=10, snap_valid=1, running=0, state HALTED.
- WIDTH=4, SAT=0, RUN, 17 events on ch1 -> count 1, ovf[1]=1. Repeat with SAT=1 -> count 15, ovf[1]=1.
- In RUN with counter at 5, assert snap and event together -> snap=5, live=6. The next cycle with clear plus event -> all 0, IDLE, ovf=0, snap_valid=0.
- HALTED at 20, pulse start with stop=1 -> stays HALTED at 20. Start with stop=0 then 3 events -> 23.
- Drop stop mid-run and assert reset asynchronously between edges -> outputs 0 before the next edge. sel=3 with NUM_CH=3 -> count_out=0.
